// File: rtl/dpram_sync_fifo_if.sv
// Handshake bundle between a producer/consumer (master) and dpram_sync_fifo (slave).
// Optional error-flag signals appear only when FIFO_ERR_FLAGS_EN is defined.
interface dpram_sync_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  w_en;
  logic                  cs_w;
  logic                  r_en;
  logic                  cs_r;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, cs_w, r_en, cs_r, data_in,
    input  data_out, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  w_en, cs_w, r_en, cs_r, data_in,
    output data_out, full, empty, almost_full, almost_empty, overflow, underflow
  );
`else
  modport master (
    output w_en, cs_w, r_en, cs_r, data_in,
    input  data_out, full, empty, almost_full, almost_empty
  );

  modport slave (
    input  w_en, cs_w, r_en, cs_r, data_in,
    output data_out, full, empty, almost_full, almost_empty
  );
`endif
endinterface

// File: rtl/dpram_sync_fifo.sv
// Single-clock FIFO on a simple dual-port RAM (one write port, one read port).
// Registered read data (1-cycle latency), status flags decoded from the count.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
// DEPTH must be a power of two and at least 4 so the pointers wrap naturally.
module dpram_sync_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  dpram_sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           count;
  logic                  wr_ok;
  logic                  rd_ok;

  // Chip select fully gates each port; full/empty block the offending side.
  assign wr_ok = bus.w_en & bus.cs_w & ~bus.full;
  assign rd_ok = bus.r_en & bus.cs_r & ~bus.empty;

  assign bus.full         = (count == DEPTH_C);
  assign bus.empty        = (count == '0);
  assign bus.almost_full  = (count >= DEPTH_C - 1'b1);
  assign bus.almost_empty = (count <= (AW+1)'(1));

  // RAM write port; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= bus.data_in;
    end
  end

  // RAM read port with output register; holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out <= '0;
    end else if (rd_ok) begin
      bus.data_out <= mem[rptr];
    end
  end

  // Pointer advance; power-of-two depth makes the wrap implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  // Occupancy tracking; a simultaneous read and write cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags: record any request that hit a full/empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (bus.w_en & bus.cs_w & bus.full)  bus.overflow  <= 1'b1;
      if (bus.r_en & bus.cs_r & bus.empty) bus.underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dpram_sync_fifo.sv
// Self-checking bench for dpram_sync_fifo: a table of directed fill/drain vectors,
// hand-written corner sequences, and randomized traffic against a queue model.
module tb_dpram_sync_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 8;

  logic clk;
  logic rst_n;

  dpram_sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

  dpram_sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of stored words plus the last read word.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          ov_m;
  logic          uf_m;

  typedef struct {
    logic          w_en;
    logic          cs_w;
    logic          r_en;
    logic          cs_r;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          af;
    logic          ae;
  } vec_t;

  vec_t tbl[38];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic cw, input logic r, input logic cr,
                       input logic [DW-1:0] d);
    bus.w_en    = w;
    bus.cs_w    = cw;
    bus.r_en    = r;
    bus.cs_r    = cr;
    bus.data_in = d;
  endtask

  // One clock edge: model absorbs the sampled inputs, then outputs settle.
  task automatic step();
    logic wr;
    logic rd;
    int   n;
    @(posedge clk);
    wr = bus.w_en & bus.cs_w;
    rd = bus.r_en & bus.cs_r;
    n  = q.size();
    if (wr && n == DEPTH) ov_m = 1'b1;
    if (rd && n == 0)     uf_m = 1'b1;
    if (rd && n > 0)      exp_dout = q.pop_front();
    if (wr && n < DEPTH)  q.push_back(bus.data_in);
    #1;
    $display("[TB] t=%0t wr=%0b rd=%0b din=%02h dout=%02h cnt_model=%0d",
             $time, wr, rd, bus.data_in, bus.data_out, q.size());
  endtask

  task automatic check_model();
    chk("dout",  bus.data_out,     exp_dout);
    chk("full",  bus.full,         q.size() == DEPTH);
    chk("empty", bus.empty,        q.size() == 0);
    chk("afull", bus.almost_full,  q.size() >= DEPTH - 1);
    chk("aempty", bus.almost_empty, q.size() <= 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow",  bus.overflow,  ov_m);
    chk("underflow", bus.underflow, uf_m);
`endif
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    ov_m     = 1'b0;
    uf_m     = 1'b0;
  endtask

  // Reset asserted between edges; flags must clear before any clock edge.
  task automatic do_reset();
    drive(0, 0, 0, 0, '0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_empty",  bus.empty,        1);
    chk("rst_aempty", bus.almost_empty, 1);
    chk("rst_full",   bus.full,         0);
    chk("rst_afull",  bus.almost_full,  0);
    chk("rst_dout",   bus.data_out,     0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      drive(1, 1, 0, 0, base + DW'(i));
      step();
      check_model();
    end
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 1, 1, '0);
      step();
      check_model();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] wrap_exp[12];
    int            wprob;
    int            rprob;

    // Directed table: 21 writes from reset, then 17 reads. Expected values
    // follow from count arithmetic alone.
    for (int i = 1; i <= 21; i++) begin
      int c;
      c = (i > DEPTH) ? DEPTH : i;
      tbl[i-1] = '{w_en: 1, cs_w: 1, r_en: 0, cs_r: 0, din: DW'(i), dout: '0,
                   full: (c == DEPTH), empty: 1'b0, af: (c >= DEPTH-1), ae: (c <= 1)};
    end
    for (int j = 1; j <= 17; j++) begin
      int c;
      int k;
      k = (j > DEPTH) ? DEPTH : j;
      c = DEPTH - k;
      tbl[20+j] = '{w_en: 0, cs_w: 0, r_en: 1, cs_r: 1, din: '0, dout: DW'(k),
                    full: 1'b0, empty: (c == 0), af: (c >= DEPTH-1), ae: (c <= 1)};
    end

    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0);
    model_reset();
    #1;
    do_reset();

    for (int i = 0; i < 38; i++) begin
      drive(tbl[i].w_en, tbl[i].cs_w, tbl[i].r_en, tbl[i].cs_r, tbl[i].din);
      step();
      chk($sformatf("tbl%0d_dout", i),   bus.data_out,     tbl[i].dout);
      chk($sformatf("tbl%0d_full", i),   bus.full,         tbl[i].full);
      chk($sformatf("tbl%0d_empty", i),  bus.empty,        tbl[i].empty);
      chk($sformatf("tbl%0d_afull", i),  bus.almost_full,  tbl[i].af);
      chk($sformatf("tbl%0d_aempty", i), bus.almost_empty, tbl[i].ae);
    end
`ifdef FIFO_ERR_FLAGS_EN
    chk("tbl_overflow",  bus.overflow,  1);
    chk("tbl_underflow", bus.underflow, 1);
`endif

    // Both enables while empty: only the write lands, no bypass.
    drive(1, 1, 1, 1, 8'hA5);
    step();
    chk("empty_both_empty",  bus.empty,        0);
    chk("empty_both_aempty", bus.almost_empty, 1);
    chk("empty_both_dout",   bus.data_out,     8'h10);
    drive(0, 0, 1, 1, '0);
    step();
    chk("empty_both_read", bus.data_out, 8'hA5);
    chk("empty_both_after", bus.empty,   1);

    // Both enables while full: only the read lands.
    push_n(16, 8'h01);
    drive(1, 1, 1, 1, 8'hEE);
    step();
    chk("full_both_dout",  bus.data_out,    8'h01);
    chk("full_both_full",  bus.full,        0);
    chk("full_both_afull", bus.almost_full, 1);
    pop_n(15);
    chk("full_both_last", bus.data_out, 8'h10);

    // Both enables at count 5: count unchanged, oldest word returned.
    push_n(5, 8'h31);
    drive(1, 1, 1, 1, 8'h36);
    step();
    chk("mid_both_dout",   bus.data_out,     8'h31);
    chk("mid_both_aempty", bus.almost_empty, 0);
    chk("mid_both_afull",  bus.almost_full,  0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, '0);
      step();
      chk("mid_order", bus.data_out, 8'h32 + DW'(i));
    end
    chk("mid_empty", bus.empty, 1);

    // Chip-select gating on each port.
    drive(1, 0, 0, 0, 8'h55);
    for (int i = 0; i < 4; i++) step();
    chk("csw_empty", bus.empty, 1);
    push_n(3, 8'h61);
    drive(0, 0, 1, 0, '0);
    for (int i = 0; i < 3; i++) step();
    chk("csr_dout",   bus.data_out,     8'h36);
    chk("csr_aempty", bus.almost_empty, 0);
    pop_n(3);

    // Wrap: write 10, read 8, write 10, then read the 12 survivors.
    push_n(10, 8'h80);
    pop_n(8);
    push_n(10, 8'h90);
    wrap_exp[0] = 8'h88;
    wrap_exp[1] = 8'h89;
    for (int i = 0; i < 10; i++) wrap_exp[2+i] = 8'h90 + DW'(i);
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 1, '0);
      step();
      chk("wrap_order", bus.data_out, wrap_exp[i]);
    end
    chk("wrap_empty", bus.empty, 1);

    // Mid-stream asynchronous reset.
    push_n(3, 8'hC0);
    do_reset();
    check_model();

    // Randomized traffic with phases biased toward filling or draining.
    for (int k = 0; k < 2000; k++) begin
      wprob = ((k / 150) % 2 == 0) ? 75 : 25;
      rprob = 100 - wprob;
      drive(($urandom_range(99) < wprob), ($urandom_range(9) != 0),
            ($urandom_range(99) < rprob), ($urandom_range(9) != 0),
            DW'($urandom));
      step();
      check_model();
    end

    drive(0, 0, 0, 0, '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dpram_sync_fifo.md
Name: dpram_sync_fifo

Overview:
Single-clock synchronous FIFO built on a simple dual-port RAM with one write port and one read port. It provides full, empty, almost_full and almost_empty status flags. Each port has a chip-select gate. It is a general-purpose rate buffer between a producer and a consumer in the same clock domain.

Parameters:
DEPTH, 16, number of entries; must be a power of two and at least 4.
DATA_WIDTH, 8, width of each data word in bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous and active-low.
w_en  input  1  write request.
cs_w  input  1  write-port chip select; a write needs w_en=1 and cs_w=1.
r_en  input  1  read request.
cs_r  input  1  read-port chip select; a read needs r_en=1 and cs_r=1.
data_in  input  DATA_WIDTH  write data, sampled on an accepted write.
data_out  output  DATA_WIDTH  registered read data.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= DEPTH-1 (also high while full).
almost_empty  output  1  count <= 1 (also high while empty).

Behaviour:
- One clock; reset is asynchronous and active-low: clk, rst_n.
- Internal state:
  - storage array of DEPTH x DATA_WIDTH;
  - write pointer and read pointer, each log2(DEPTH) bits, wrapping from DEPTH-1 to 0;
  - occupancy count of log2(DEPTH)+1 bits.
- Reset (rst_n=0, takes effect immediately):
  - pointers = 0, count = 0, data_out = 0;
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0;
  - RAM contents are not cleared.
- Write acceptance: wr_ok = w_en & cs_w & ~full. On the rising edge: mem[wptr] <= data_in, then wptr increments.
- Read acceptance: rd_ok = r_en & cs_r & ~empty. On the rising edge: data_out <= mem[rptr], then rptr increments.
- Read latency is 1 clock: data_out is valid after the edge that accepts the read. data_out holds its last value when no read is accepted.
- Count update per edge:
  - wr_ok only: count +1.
  - rd_ok only: count -1.
  - both or neither: count unchanged.
- Flags are combinational decodes of the registered count, so they change right after the edge.
- Boundary conditions:
  - Write while full: ignored; no pointer, count or RAM change.
  - Read while empty: ignored; data_out holds.
  - Full with w_en and r_en both active: only the read is accepted; count drops to DEPTH-1.
  - Empty with both active: only the write is accepted; count becomes 1. There is no write-to-read bypass, so the word is readable from the next cycle.
  - Partially filled with both active: both are accepted; the read returns the oldest word.
  - Chip select low on a port: that port is completely inactive, regardless of its enable.
  - Pointer wrap-around is transparent; ordering is strictly first-in, first-out.
  - Reset asserted mid-operation: the FIFO is emptied asynchronously. Stored data is treated as lost even though the RAM is not cleared.
- data_in is sampled only on accepted writes.

Optional Feature:
Macro FIFO_ERR_FLAGS_EN.
- Defined:
  - adds output ports overflow (1 bit) and underflow (1 bit);
  - overflow sets on an edge where w_en & cs_w & full;
  - underflow sets on an edge where r_en & cs_r & empty;
  - both are sticky until rst_n=0, which clears them to 0.
- Not defined: the ports and logic are absent; other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with all inputs 0 -> empty=1, almost_empty=1, full=0, almost_full=0, data_out=0.
- Fill: w_en=cs_w=1, write 0x01..0x15 (21 writes), r_en=0 -> almost_empty falls after the 2nd write; almost_full rises after the 15th; full rises after the 16th; writes 17-21 are dropped and count stays 16.
- Drain and order: r_en=cs_r=1 from full, w_en=0 -> data_out is 0x01..0x10 in order, each one cycle after its accepting edge; empty=1 after the 16th read; further reads leave data_out=0x10.
- Simultaneous: with count=16, assert both enables for one cycle -> read 0x01 accepted, write dropped, count 15. At count 0, both for one cycle -> only the write is accepted, count 1. At count 5, both -> count stays 5 and the oldest word is returned.
- Chip select gating: w_en=1, cs_w=0 for 4 cycles -> count stays 0; r_en=1, cs_r=0 with count 3 -> data_out unchanged.
- Wrap and reset: write 10, read 8, write 10 (pointers wrap) -> reads return the 12 remaining words in FIFO order. Asserting rst_n=0 mid-stream clears the flags immediately, without waiting for a clock edge.
